// File: rtl/raster_stamp_serializer.sv
// Serializes IN_QUADS-wide stamp bundles into OUT_LANES-wide beats, skipping empty beats.
// First beat one cycle after in_fire; one beat per cycle; upstream stalls on in_ready.
module raster_stamp_serializer #(
  parameter int IN_QUADS    = 4,
  parameter int OUT_LANES   = 2,
  parameter int STAMP_WIDTH = 64,
  localparam int BEATS      = IN_QUADS / OUT_LANES,
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [IN_QUADS*STAMP_WIDTH-1:0]   in_stamps,
  input  logic [IN_QUADS-1:0]               in_mask,
  input  logic                              in_done,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [OUT_LANES*STAMP_WIDTH-1:0]  out_stamps,
  output logic [OUT_LANES-1:0]              out_mask,
  output logic                              out_done,
  input  logic                              out_ready,
  output logic [31:0]                       perf_stamps
);

  localparam int SLW = OUT_LANES * STAMP_WIDTH;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                          state_q, state_d;
  logic [BW-1:0]                   beat_q, beat_d;
  logic [IN_QUADS*STAMP_WIDTH-1:0] stamps_q;
  logic [IN_QUADS-1:0]             mask_q;
  logic                            done_q;
  logic [31:0]                     perf_q, perf_d;

  logic [BEATS-1:0] nz_in, nz_held;
  logic [BW-1:0]    first_in, last_held, next_held, load_beat;
  logic             is_last, in_fire, out_fire, load;
  logic [OUT_LANES-1:0] slice_mask;
  logic [31:0]      pop;

  // Per-beat "has any valid stamp" flags for the incoming and held bundles.
  always_comb begin
    nz_in   = '0;
    nz_held = '0;
    for (int b = 0; b < BEATS; b++) begin
      nz_in[b]   = |in_mask[b*OUT_LANES +: OUT_LANES];
      nz_held[b] = |mask_q[b*OUT_LANES +: OUT_LANES];
    end
  end

  // A done-only bundle has no nonzero slice, so last defaults to BEATS-1.
  always_comb begin
    first_in  = '0;
    last_held = BW'(BEATS - 1);
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (nz_in[b]) first_in = BW'(b);
    end
    for (int b = 0; b < BEATS; b++) begin
      if (nz_held[b]) last_held = BW'(b);
    end
  end

  always_comb begin
    next_held = last_held;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (nz_held[b] && (BW'(b) > beat_q)) next_held = BW'(b);
    end
  end

  assign is_last   = (beat_q == last_held);
  assign load_beat = (|in_mask) ? first_in : BW'(BEATS - 1);

  always_comb begin
    out_stamps = '0;
    slice_mask = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BW'(b)) begin
        out_stamps = stamps_q[b*SLW +: SLW];
        slice_mask = mask_q[b*OUT_LANES +: OUT_LANES];
      end
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_mask  = out_valid ? slice_mask : '0;
  assign out_done  = out_valid & done_q & is_last;
  assign in_ready  = (state_q == IDLE) ? 1'b1 : (out_ready & is_last);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // An all-zero, not-done bundle is accepted but never stored.
  assign load     = in_fire & ((|in_mask) | in_done);

  always_comb begin
    pop = '0;
    for (int i = 0; i < OUT_LANES; i++) begin
      pop = pop + 32'(out_mask[i]);
    end
    perf_d = out_fire ? (perf_q + pop) : perf_q;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SEND;
          beat_d  = load_beat;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (!is_last) begin
            beat_d = next_held;
          end else if (load) begin
            beat_d = load_beat;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      perf_q  <= perf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      stamps_q <= in_stamps;
      mask_q   <= in_mask;
      done_q   <= in_done;
    end
  end

  assign perf_stamps = perf_q;

endmodule

// File: tb/tb_raster_stamp_serializer.sv
// Randomized and directed bench for raster_stamp_serializer with a beat-queue reference model.
module tb_raster_stamp_serializer;

  localparam int IQ = 4;
  localparam int OL = 2;
  localparam int SW = 64;
  localparam int NB = IQ / OL;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic [IQ*SW-1:0]   in_stamps = '0;
  logic [IQ-1:0]      in_mask = '0;
  logic               in_done = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic [OL*SW-1:0]   out_stamps;
  logic [OL-1:0]      out_mask;
  logic               out_done;
  logic               out_ready = 1'b1;
  logic [31:0]        perf_stamps;

  raster_stamp_serializer #(.IN_QUADS(IQ), .OUT_LANES(OL), .STAMP_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_stamps(in_stamps),
    .in_mask(in_mask), .in_done(in_done), .in_ready(in_ready),
    .out_valid(out_valid), .out_stamps(out_stamps), .out_mask(out_mask),
    .out_done(out_done), .out_ready(out_ready), .perf_stamps(perf_stamps)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OL*SW-1:0] s;
    logic [OL-1:0]    m;
    logic             d;
  } beat_t;

  beat_t      q[$];
  beat_t      log_b[$];
  int         log_cyc[$];
  logic [31:0] perf_m = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats of one accepted bundle: each nonempty lane group in order,
  // done on the last one; a done-only bundle yields one empty done beat.
  task automatic model_push(input logic [IQ*SW-1:0] st, input logic [IQ-1:0] mk, input logic dn);
    int    last;
    beat_t e;
    last = -1;
    for (int b = 0; b < NB; b++) if (mk[b*OL +: OL] != 0) last = b;
    if (last < 0) begin
      if (dn) begin
        e.s = st[(NB-1)*OL*SW +: OL*SW];
        e.m = '0;
        e.d = 1'b1;
        q.push_back(e);
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (mk[b*OL +: OL] != 0) begin
          e.s = st[b*OL*SW +: OL*SW];
          e.m = mk[b*OL +: OL];
          e.d = dn && (b == last);
          q.push_back(e);
        end
      end
    end
  endtask

  function automatic int popc(input logic [OL-1:0] m);
    int c;
    c = 0;
    for (int i = 0; i < OL; i++) c += int'(m[i]);
    return c;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      perf_m = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_mask", out_mask, 0);
      chk("rst_out_done", out_done, 0);
      chk("rst_perf", perf_stamps, 0);
    end else begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, (q.size() == 0) || (out_ready && q.size() == 1));
      chk("perf", perf_stamps, perf_m);
      if (q.size() != 0) begin
        chk("out_stamps", out_stamps, q[0].s);
        chk("out_mask", out_mask, q[0].m);
        chk("out_done", out_done, q[0].d);
      end
      if (out_valid && out_ready) begin
        beat_t e;
        e.s = out_stamps;
        e.m = out_mask;
        e.d = out_done;
        log_b.push_back(e);
        log_cyc.push_back(cyc + 1);
        if (q.size() != 0) begin
          perf_m = perf_m + 32'(popc(q[0].m));
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) model_push(in_stamps, in_mask, in_done);
    end
  end

  function automatic logic [IQ*SW-1:0] a_stamps();
    logic [IQ*SW-1:0] s;
    for (int i = 0; i < IQ; i++) s[i*SW +: SW] = 64'hA0 + 64'(i);
    return s;
  endfunction

  // Returns at posedge+1 right after the edge that accepted the bundle.
  task automatic send_bundle(input logic [IQ*SW-1:0] st, input logic [IQ-1:0] mk, input logic dn);
    bit acc;
    int n;
    in_valid  = 1'b1;
    in_stamps = st;
    in_mask   = mk;
    in_done   = dn;
    acc = 0;
    n = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_err++;
      $display("FAIL send_timeout: got no in_ready expected accept");
    end
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) begin
      n_err++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [31:0] p0;
    logic [IQ*SW-1:0] rs;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Full bundle, two beats back to back.
    base = log_b.size();
    send_bundle(a_stamps(), 4'b1111, 1'b0);
    wait_idle();
    chk("t1_nbeats", 128'(log_b.size() - base), 2);
    chk("t1_b0", log_b[base].s, 128'h00000000000000A1_00000000000000A0);
    chk("t1_b0_mask", log_b[base].m, 2'b11);
    chk("t1_b1", log_b[base+1].s, 128'h00000000000000A3_00000000000000A2);
    chk("t1_b1_done", log_b[base+1].d, 0);
    chk("t1_lat", 128'(log_cyc[base] - acc_cyc), 1);
    chk("t1_consec", 128'(log_cyc[base+1] - log_cyc[base]), 1);
    chk("t1_perf", perf_stamps, 4);

    // Empty low beat is skipped; in_ready high while the only beat fires.
    base = log_b.size();
    send_bundle(a_stamps(), 4'b1100, 1'b0);
    chk("t2_vld", out_valid, 1);
    chk("t2_rdy_same", in_ready, 1);
    wait_idle();
    chk("t2_nbeats", 128'(log_b.size() - base), 1);
    chk("t2_b0", log_b[base].s, 128'h00000000000000A3_00000000000000A2);
    chk("t2_perf", perf_stamps, 6);

    // Done-only bundle, then an empty non-done bundle that must vanish.
    base = log_b.size();
    send_bundle(a_stamps(), 4'b0000, 1'b1);
    wait_idle();
    chk("t3_nbeats", 128'(log_b.size() - base), 1);
    chk("t3_mask", log_b[base].m, 0);
    chk("t3_done", log_b[base].d, 1);
    chk("t3_perf", perf_stamps, 6);
    base = log_b.size();
    send_bundle(a_stamps(), 4'b0000, 1'b0);
    wait_idle();
    chk("t3_drop", 128'(log_b.size() - base), 0);

    // Backpressure on a single done beat.
    out_ready = 1'b0;
    base = log_b.size();
    send_bundle(a_stamps(), 4'b0011, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_vld", out_valid, 1);
      chk("t4_hold_rdy", in_ready, 0);
      chk("t4_hold_dat", out_stamps, 128'h00000000000000A1_00000000000000A0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    chk("t4_nbeats", 128'(log_b.size() - base), 1);
    chk("t4_done", log_b[base].d, 1);

    // Three full bundles streamed with no bubbles.
    base = log_b.size();
    p0 = perf_stamps;
    for (int k = 0; k < 3; k++) send_bundle(a_stamps(), 4'b1111, 1'b0);
    wait_idle();
    chk("t5_nbeats", 128'(log_b.size() - base), 6);
    for (int k = 0; k < 5; k++) chk("t5_nobubble", 128'(log_cyc[base+k+1] - log_cyc[base+k]), 1);
    chk("t5_perf", perf_stamps - p0, 12);

    // Reset while the second beat is being presented.
    send_bundle(a_stamps(), 4'b1111, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_vld", out_valid, 0);
    chk("t6_async_perf", perf_stamps, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    base = log_b.size();
    send_bundle(a_stamps(), 4'b0110, 1'b1);
    wait_idle();
    chk("t6_nbeats", 128'(log_b.size() - base), 2);
    chk("t6_b1_done", log_b[base+1].d, 1);
    chk("t6_perf", perf_stamps, 2);

    // Random bundles with random consumer stalls.
    rand_rdy = 1;
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < IQ*SW/32; i++) rs[i*32 +: 32] = $urandom;
      send_bundle(rs, IQ'($urandom_range(0, (1 << IQ) - 1)), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_rdy = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/raster_stamp_serializer.md
Name: raster_stamp_serializer

Overview:
- Sits directly downstream of the raster unit's request port.
- Accepts one bundle of IN_QUADS stamps per handshake, with a per-stamp valid mask and a done flag.
- Re-emits the stamps OUT_LANES at a time to a narrower consumer (the per-core raster request port).
- Skips beats that contain no valid stamps, propagates done on the final beat, and counts issued stamps for perf.

Parameters:
- IN_QUADS, 4: stamps per input bundle. Must be a multiple of OUT_LANES.
- OUT_LANES, 2: stamps per output beat. Must be ≥1.
- STAMP_WIDTH, 64: packed raster stamp width in bits.
- Derived BEATS = IN_QUADS/OUT_LANES. BW = max(1, clog2(BEATS)).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  bundle valid
- in_stamps  in  IN_QUADS*STAMP_WIDTH  stamps; stamp i occupies bits [i*STAMP_WIDTH +: STAMP_WIDTH]
- in_mask  in  IN_QUADS  per-stamp valid
- in_done  in  1  terminal bundle; may carry mask 0
- in_ready  out  1  bundle accepted when in_valid & in_ready
- out_valid  out  1  beat valid
- out_stamps  out  OUT_LANES*STAMP_WIDTH  beat stamps
- out_mask  out  OUT_LANES  beat lane valid
- out_done  out  1  last beat of a done bundle
- out_ready  in  1  consumer ready
- perf_stamps  out  32  count of valid stamps issued (wraps)

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release): state=IDLE, beat=0, in_ready=1, out_valid=0, out_mask=0, out_done=0, perf_stamps=0. The stored bundle register is don't-care.
- Storage: a single holding register for stamps, mask and done, plus beat index `beat`. State is IDLE or SEND.
- Handshakes: fires are in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
  - out_valid must stay high, and out_* must stay stable, until out_fire.
  - in_ready does not depend combinationally on in_valid.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_fire, latch the bundle, set beat = index of the first beat with a nonzero mask slice, and go to SEND.
  - If the mask is all zero and done=1, set beat=BEATS-1 and go to SEND, producing a single done beat with out_mask=0.
  - If the mask is all zero and done=0, drop the bundle and stay in IDLE.
- SEND:
  - out_valid=1.
  - out_stamps and out_mask come from the slice [beat*OUT_LANES +: OUT_LANES] of the held bundle.
  - The last beat is the highest-indexed beat with a nonzero mask slice. For a done-only bundle it is BEATS-1.
  - out_done = held_done & (beat == last).
  - On out_fire with beat != last, advance beat to the next nonzero slice, skipping empty slices.
  - On out_fire with beat == last, go to IDLE.
- Back-to-back bundles:
  - In SEND, in_ready = out_ready & (beat == last).
  - If in_fire and the final out_fire happen in the same cycle, the new bundle loads and the state stays SEND, giving zero bubbles.
- Latency: first out_valid appears 1 cycle after in_fire. Sustained throughput is one beat per cycle.
- perf_stamps: on each out_fire, add popcount(out_mask) modulo 2^32.
- Reset mid-operation discards the held bundle immediately. No partial beat is emitted after reset release.
- The block does not buffer more than one bundle. Upstream stalls via in_ready.

Test Plan:
- IN_QUADS=4, OUT_LANES=2, out_ready=1: send mask=4'b1111, done=0, stamps 0xA0..0xA3 → two beats on consecutive cycles starting 1 cycle after in_fire:
  - beat 1: {0xA1,0xA0}, mask 2'b11, out_done=0
  - beat 2: {0xA3,0xA2}, mask 2'b11, out_done=0
  - perf_stamps=4
- Skip empty beat, mask=4'b1100 → single beat {0xA3,0xA2}, mask 11, out_done=0. in_ready is high in the same cycle as that beat fires.
- Done-only bundle, mask=0, done=1 → one beat with out_mask=00 and out_done=1; perf_stamps unchanged. A mask=0, done=0 bundle produces no beat.
- Backpressure: out_ready=0 for 5 cycles while holding a mask=4'b0011, done=1 bundle → out_valid and out_* stay stable and in_ready=0. After out_ready=1, exactly one beat fires with out_done=1.
- Streaming: 3 full bundles offered continuously with out_ready=1 → 6 beats in 6 consecutive cycles, no bubbles, perf_stamps=12.
- Assert reset low during SEND of the second beat → out_valid drops asynchronously and perf_stamps=0. After release, a new bundle is handled normally.
